// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
package display_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SCAN} state_e;

  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  // A digit is hidden when it and every higher nibble of the shown half are zero.
  function automatic logic lz_hide(input logic [15:0] half, input logic [1:0] d,
                                   input logic lz);
    logic [15:0] hi;
    hi = half >> {d, 2'b00};
    return lz && (d != 2'd0) && (hi == 16'h0000);
  endfunction

endpackage

// File: rtl/refresh_ticker.sv
// Prescaler: counts 0..DIV-1 while enabled, pulses tc_o on the last count.
module refresh_ticker #(
  parameter int DIV = 200000,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign cnt_o = cnt_q;
  assign tc_o  = en_i && !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (en_i)   cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Frame sequencer: fetch a snapshot, then scan its four nibbles onto the anodes.
module ssd_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV   = 200000,
  parameter int FETCH_TIMEOUT = 16,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             page,
  input  logic             lz_blank,
  output logic             fetch_req,
  input  logic             fetch_ack,
  input  logic [WIDTH-1:0] fetch_data,
  output logic [3:0]       disp_num,
  output logic [3:0]       an,
  output logic [1:0]       digit_idx,
  output logic             stale,
  output logic             frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   snap_q, snap_d;
  logic          page_q, page_d;
  logic          lz_q, lz_d;
  logic          stale_q, stale_d;
  logic          req_q, req_d;
  logic [1:0]    digit_q, digit_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    num_q, num_d;
  logic [15:0]   half_d;
  logic          capture, tc;
  logic [CW-1:0] unused_tick;

  generate
    if (WIDTH > 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^fetch_data[WIDTH-1:32];
    end
  endgenerate

  refresh_ticker #(.DIV(REFRESH_DIV)) u_ticker (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i ((state_q != SCAN) || !enable),
    .en_i  (state_q == SCAN),
    .cnt_o (unused_tick),
    .tc_o  (tc)
  );

  // Only a live request can be acknowledged; enable low abandons it.
  assign capture = (state_q == FETCH) && req_q && fetch_ack && enable;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    page_d  = page_q;
    lz_d    = lz_q;
    stale_d = stale_q;
    digit_d = digit_q;
    to_d    = '0;
    case (state_q)
      IDLE: if (enable) state_d = FETCH;
      FETCH: begin
        to_d = to_q + 1'b1;
        if (capture) begin
          snap_d  = fetch_data[31:0];
          page_d  = page;
          lz_d    = lz_blank;
          stale_d = 1'b0;
          state_d = SCAN;
          digit_d = 2'd0;
        end else if (to_q == TO_LAST) begin
          stale_d = 1'b1;
          state_d = SCAN;
          digit_d = 2'd0;
        end
      end
      SCAN: begin
        if (tc) begin
          if (digit_q == 2'd3) state_d = FETCH;
          else                 digit_d = digit_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      digit_d = digit_q;
      to_d    = '0;
    end
  end

  // Display registers are loaded from next-state values so they line up with digit_idx.
  always_comb begin
    req_d  = (state_d == FETCH);
    half_d = page_d ? snap_d[31:16] : snap_d[15:0];
    an_d   = AN_OFF;
    num_d  = 4'h0;
    if ((state_d == SCAN) && !lz_hide(half_d, digit_d, lz_d)) begin
      an_d  = AN_OFF & ~(4'b0001 << digit_d);
      num_d = half_d[{digit_d, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      page_q  <= 1'b0;
      lz_q    <= 1'b0;
      stale_q <= 1'b1;
      req_q   <= 1'b0;
      digit_q <= 2'd0;
      to_q    <= '0;
      an_q    <= AN_OFF;
      num_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      page_q  <= page_d;
      lz_q    <= lz_d;
      stale_q <= stale_d;
      req_q   <= req_d;
      digit_q <= digit_d;
      to_q    <= to_d;
      an_q    <= an_d;
      num_q   <= num_d;
    end
  end

  assign fetch_req  = req_q;
  assign an         = an_q;
  assign disp_num   = num_q;
  assign digit_idx  = digit_q;
  assign stale      = stale_q;
  assign frame_done = (state_q == SCAN) && (digit_q == 2'd3) && tc;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with REFRESH_DIV=4, FETCH_TIMEOUT=3.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0, page = 1'b0, lz_blank = 1'b0;
  logic        fetch_ack = 1'b0;
  logic [31:0] fetch_data = '0;
  logic        fetch_req, stale, frame_done;
  logic [3:0]  disp_num, an;
  logic [1:0]  digit_idx;

  int n_run = 0, n_fail = 0;

  ssd_scan_ctrl #(.REFRESH_DIV(4), .FETCH_TIMEOUT(3), .WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .page(page), .lz_blank(lz_blank),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .disp_num(disp_num), .an(an), .digit_idx(digit_idx), .stale(stale),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ack `dly` cycles after the request is seen; returns in scan cycle 0.
  task automatic do_fetch(input logic [31:0] data, input int dly);
    int w = 0;
    while (fetch_req !== 1'b1 && w < 8) begin step(); w++; end
    chk("req_seen", fetch_req, 1'b1);
    step(dly);
    fetch_ack = 1'b1; fetch_data = data;
    step();
    fetch_ack = 1'b0; fetch_data = '0;
  endtask

  task automatic check_frame(input logic [15:0] an4, input logic [15:0] num4);
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 4; t++) begin
        chk($sformatf("an_d%0d_t%0d", d, t), an, an4[4*d +: 4]);
        chk($sformatf("num_d%0d_t%0d", d, t), disp_num, num4[4*d +: 4]);
        chk($sformatf("idx_d%0d_t%0d", d, t), digit_idx, d);
        chk($sformatf("fd_d%0d_t%0d", d, t), frame_done, (d == 3 && t == 3));
        chk($sformatf("req_d%0d_t%0d", d, t), fetch_req, 1'b0);
        step();
      end
    end
    chk("req_after_frame", fetch_req, 1'b1);
  endtask

  initial begin
    enable = 1'b1;
    step(2);
    chk("rst_req", fetch_req, 1'b0);
    chk("rst_an", an, 4'hF);
    chk("rst_num", disp_num, 4'h0);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_stale", stale, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    #2 reset_n = 1'b1;
    step();
    chk("req_after_rst", fetch_req, 1'b1);

    // Ack lands on the last timeout cycle: capture must win.
    do_fetch(32'h0000_1234, 2);
    chk("stale_cap", stale, 1'b0);
    check_frame(16'h7BDE, 16'h1234);

    page = 1'b1;
    do_fetch(32'hABCD_0000, 1);
    page = 1'b0;
    check_frame(16'h7BDE, 16'hABCD);

    lz_blank = 1'b1;
    do_fetch(32'h0000_0005, 0);
    lz_blank = 1'b0;
    check_frame(16'hFFFE, 16'h0005);

    do_fetch(32'h0000_1234, 0);
    check_frame(16'h7BDE, 16'h1234);

    // No ack: request stays up exactly three cycles, snapshot reused.
    chk("to_req0", fetch_req, 1'b1);
    step();
    chk("to_req1", fetch_req, 1'b1);
    step();
    chk("to_req2", fetch_req, 1'b1);
    step();
    chk("to_req_low", fetch_req, 1'b0);
    chk("to_stale", stale, 1'b1);
    check_frame(16'h7BDE, 16'h1234);

    do_fetch(32'h0000_1234, 0);
    step(8);
    chk("en_idx2", digit_idx, 2'd2);
    chk("en_an2", an, 4'hB);
    enable = 1'b0;
    step();
    chk("dis_an", an, 4'hF);
    chk("dis_req", fetch_req, 1'b0);
    chk("dis_stale", stale, 1'b0);
    step();
    chk("dis_an2", an, 4'hF);
    enable = 1'b1;
    step();
    chk("reen_req", fetch_req, 1'b1);

    // Asynchronous reset mid-FETCH, sampled before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", fetch_req, 1'b0);
    chk("arst_an", an, 4'hF);
    chk("arst_stale", stale, 1'b1);
    #1 reset_n = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
